// File: rtl/ctrl_pkg.sv
// ctrl_pkg -- shared encodings for the multicycle controller: FSM states,
// instruction field values, datapath select codes and funct decode helpers.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEM_ADR = 4'd2,
        MEM_RD  = 4'd3,
        MEM_WB  = 4'd4,
        MEM_WR  = 4'd5,
        EXEC_R  = 4'd6,
        EXEC_I  = 4'd7,
        ALU_WB  = 4'd8,
        BRANCH  = 4'd9
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_SYS = 2'b11;

    localparam logic [3:0] FUNCT_AND = 4'b0000;
    localparam logic [3:0] FUNCT_SUB = 4'b0010;
    localparam logic [3:0] FUNCT_ADD = 4'b0100;
    localparam logic [3:0] FUNCT_CMP = 4'b1010;
    localparam logic [3:0] FUNCT_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] SRC_B_RM   = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALU_OUT = 2'b00;
    localparam logic [1:0] RES_MEM     = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    // Per-state control word held in the output register.
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       pc_write;
        logic       reg_write;
        logic       flag_write;
        logic [1:0] alu_src_b;
        logic [1:0] alu_ctrl;
        logic [1:0] result_src;
    } ctrl_out_t;

    function automatic logic [1:0] funct_alu(input logic [3:0] funct);
        case (funct)
            FUNCT_SUB, FUNCT_CMP: return ALU_SUB;
            FUNCT_AND:            return ALU_AND;
            FUNCT_ORR:            return ALU_ORR;
            default:              return ALU_ADD;
        endcase
    endfunction

    function automatic logic funct_writes(input logic [3:0] funct);
        return funct inside {FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_ORR};
    endfunction

endpackage

// File: rtl/cond_check.sv
// cond_check -- evaluates an instruction condition field against the NZCV
// flag register. Only built when COND_EXEC_EN is defined.
`ifdef COND_EXEC_EN
module cond_check
    import ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    always_comb begin
        // NOTE: give the output a value before the case so no path leaves it unassigned (no latch).
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule
`endif

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- Moore control FSM for a multicycle ARM-style datapath.
// Define COND_EXEC_EN to enable conditional execution against the flag register.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [3:0]  alu_flags,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_write,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic        flag_write,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_ctrl,
    output logic [1:0]  result_src,
    output logic [3:0]  state
);

    state_t     state_q, state_d;
    ctrl_out_t  out_q;
    logic [3:0] flags_q;
    logic       cond_pass;

    logic [1:0] op;
    logic [3:0] funct;
    logic       i_bit, u_bit, s_bit;
    assign op    = instr[27:26];
    assign i_bit = instr[25];
    assign funct = instr[24:21];
    assign u_bit = instr[23];
    assign s_bit = instr[20];

`ifdef COND_EXEC_EN
    cond_check u_cond_check (
        .cond  (instr[31:28]),
        .flags (flags_q),
        .pass  (cond_pass)
    );
    logic unused_bits;
    assign unused_bits = ^{instr[22], instr[19:0]};
`else
    // Every instruction runs as AL; the flag register is still maintained.
    assign cond_pass = 1'b1;
    logic unused_bits;
    assign unused_bits = ^{instr[31:28], instr[22], instr[19:0], flags_q};
`endif

    function automatic ctrl_out_t moore_outputs(input state_t s, input logic [3:0] fn,
                                                input logic s_flag, input logic up);
        ctrl_out_t o;
        o = '0;
        case (s)
            FETCH: begin
                o.mem_req   = 1'b1;
                o.alu_src_b = SRC_B_FOUR;
                o.alu_ctrl  = ALU_ADD;
            end
            MEM_ADR: begin
                o.alu_src_b = SRC_B_IMM;
                o.alu_ctrl  = up ? ALU_ADD : ALU_SUB;
            end
            MEM_RD: begin
                o.mem_req = 1'b1;
                o.adr_src = 1'b1;
            end
            MEM_WB: begin
                o.reg_write  = 1'b1;
                o.result_src = RES_MEM;
            end
            MEM_WR: begin
                o.mem_req   = 1'b1;
                o.mem_write = 1'b1;
                o.adr_src   = 1'b1;
            end
            EXEC_R, EXEC_I: begin
                o.alu_src_b  = (s == EXEC_I) ? SRC_B_IMM : SRC_B_RM;
                o.alu_ctrl   = funct_alu(fn);
                o.flag_write = s_flag || (fn == FUNCT_CMP);
            end
            ALU_WB: begin
                o.reg_write  = 1'b1;
                o.result_src = RES_ALU_OUT;
            end
            BRANCH: begin
                o.pc_write   = 1'b1;
                o.alu_src_b  = SRC_B_IMM;
                o.result_src = RES_ALU;
            end
            default: ;
        endcase
        return o;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (mem_ready) state_d = DECODE;
            DECODE: begin
                if (!cond_pass) begin
                    state_d = FETCH;
                end else begin
                    case (op)
                        OP_DP:  state_d = i_bit ? EXEC_I : EXEC_R;
                        OP_MEM: state_d = MEM_ADR;
                        OP_BR:  state_d = BRANCH;
                        OP_SYS: state_d = FETCH;
                        default: state_d = FETCH;
                    endcase
                end
            end
            MEM_ADR: state_d = s_bit ? MEM_RD : MEM_WR;
            MEM_RD:  if (mem_ready) state_d = MEM_WB;
            MEM_WR:  if (mem_ready) state_d = FETCH;
            EXEC_R, EXEC_I: state_d = funct_writes(funct) ? ALU_WB : FETCH;
            default: state_d = FETCH;
        endcase
    end

    // The output register is loaded with the control word of the state being
    // entered, so it always lines up with state_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
            out_q   <= moore_outputs(FETCH, 4'b0000, 1'b0, 1'b0);
            flags_q <= 4'b0000;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            out_q   <= moore_outputs(state_d, funct, s_bit, u_bit);
            if (out_q.flag_write) flags_q <= alu_flags;
        end
    end

    // IR/PC capture must coincide with the data handshake, so the fetch
    // enables follow mem_ready directly; rst gates every output low at once.
    logic fetch_done;
    assign fetch_done = rst && (state_q == FETCH) && mem_ready;

    assign mem_req    = rst && out_q.mem_req;
    assign mem_write  = rst && out_q.mem_write;
    assign adr_src    = rst && out_q.adr_src;
    assign ir_write   = fetch_done;
    assign pc_write   = (rst && out_q.pc_write) || fetch_done;
    assign reg_write  = rst && out_q.reg_write;
    assign flag_write = rst && out_q.flag_write;
    assign alu_src_b  = rst ? out_q.alu_src_b  : 2'b00;
    assign alu_ctrl   = rst ? out_q.alu_ctrl   : 2'b00;
    assign result_src = rst ? out_q.result_src : 2'b00;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl -- directed, self-checking bench for multicycle_ctrl.
// Expected state/control words are hand-derived per instruction and cycle.
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic [3:0]  alu_flags;
    logic        mem_ready;
    logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, flag_write;
    logic [1:0]  alu_src_b, alu_ctrl, result_src;
    logic [3:0]  state;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .alu_flags  (alu_flags),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .flag_write (flag_write),
        .alu_src_b  (alu_src_b),
        .alu_ctrl   (alu_ctrl),
        .result_src (result_src),
        .state      (state)
    );

    int passed = 0;
    int total  = 0;

    // Control word: {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
    //                flag_write, alu_src_b[1:0], alu_ctrl[1:0], result_src[1:0]}
    localparam logic [12:0] O_NONE          = 13'b0000000_00_00_00;
    localparam logic [12:0] O_FETCH         = 13'b1000000_10_00_00;
    localparam logic [12:0] O_FETCH_RDY     = 13'b1001100_10_00_00;
    localparam logic [12:0] O_IMM_ADD       = 13'b0000000_01_00_00;
    localparam logic [12:0] O_IMM_SUB       = 13'b0000000_01_01_00;
    localparam logic [12:0] O_IMM_SUB_FLAGS = 13'b0000001_01_01_00;
    localparam logic [12:0] O_RM_SUB_FLAGS  = 13'b0000001_00_01_00;
    localparam logic [12:0] O_RM_ORR        = 13'b0000000_00_11_00;
    localparam logic [12:0] O_RM_AND        = 13'b0000000_00_10_00;
    localparam logic [12:0] O_ALU_WB        = 13'b0000010_00_00_00;
    localparam logic [12:0] O_MEM_WB        = 13'b0000010_00_00_01;
    localparam logic [12:0] O_MEM_RD        = 13'b1010000_00_00_00;
    localparam logic [12:0] O_MEM_WR        = 13'b1110000_00_00_00;
    localparam logic [12:0] O_BRANCH        = 13'b0000100_01_00_10;

    // Third step of a branch whose condition fails (or would, if evaluated).
`ifdef COND_EXEC_EN
    localparam state_t      SKIP_S = FETCH;
    localparam logic [12:0] SKIP_O = O_FETCH;
`else
    localparam state_t      SKIP_S = BRANCH;
    localparam logic [12:0] SKIP_O = O_BRANCH;
`endif

    typedef struct packed {
        logic [31:0] instr;
        logic        ready;
        logic [3:0]  flags;
        state_t      s;
        logic [12:0] o;
    } step_t;

    function automatic logic [12:0] outs();
        return {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, flag_write,
                alu_src_b, alu_ctrl, result_src};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; instr = 32'h0; alu_flags = 4'h0; mem_ready = 1'b0;
        #1;
        total++;
        if ({state, outs()} !== {FETCH, O_NONE})
            $display("FAIL reset_async: state=%0d outs=%b expected state=%0d outs=%b", state, outs(), FETCH, O_NONE);
        else passed++;
        mem_ready = 1'b1;
        tick();
        tick();
        total++;
        if ({state, outs()} !== {FETCH, O_NONE})
            $display("FAIL reset_hold: state=%0d outs=%b expected state=%0d outs=%b", state, outs(), FETCH, O_NONE);
        else passed++;
        mem_ready = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if ({state, outs()} !== {FETCH, O_FETCH})
            $display("FAIL reset_release: state=%0d outs=%b expected state=%0d outs=%b", state, outs(), FETCH, O_FETCH);
        else passed++;
        tick();
        total++;
        if ({state, outs()} !== {FETCH, O_FETCH})
            $display("FAIL fetch_idle: state=%0d outs=%b expected state=%0d outs=%b", state, outs(), FETCH, O_FETCH);
        else passed++;
    endtask

    task automatic test_cond_exec();
        step_t seq [16];
        seq = '{
            '{32'h0A000002, 1'b1, 4'b1011, FETCH,  O_FETCH_RDY},
            '{32'h0A000002, 1'b0, 4'b1011, DECODE, O_NONE},
            '{32'h0A000002, 1'b0, 4'b1011, SKIP_S, SKIP_O},
            '{32'h0A000002, 1'b0, 4'b1011, FETCH,  O_FETCH},
            '{32'hE1510001, 1'b1, 4'b1011, FETCH,  O_FETCH_RDY},
            '{32'hE1510001, 1'b0, 4'b1011, DECODE, O_NONE},
            '{32'hE1510001, 1'b0, 4'b0100, EXEC_R, O_RM_SUB_FLAGS},
            '{32'h0A000002, 1'b1, 4'b1011, FETCH,  O_FETCH_RDY},
            '{32'h0A000002, 1'b0, 4'b1011, DECODE, O_NONE},
            '{32'h0A000002, 1'b0, 4'b1011, BRANCH, O_BRANCH},
            '{32'h1A000002, 1'b1, 4'b1011, FETCH,  O_FETCH_RDY},
            '{32'h1A000002, 1'b0, 4'b1011, DECODE, O_NONE},
            '{32'h1A000002, 1'b0, 4'b1011, SKIP_S, SKIP_O},
            '{32'hFA000002, 1'b1, 4'b1011, FETCH,  O_FETCH_RDY},
            '{32'hFA000002, 1'b0, 4'b1011, DECODE, O_NONE},
            '{32'hFA000002, 1'b0, 4'b1011, SKIP_S, SKIP_O}
        };
        for (int i = 0; i < $size(seq); i++) begin
            instr = seq[i].instr; mem_ready = seq[i].ready; alu_flags = seq[i].flags;
            #1;
            total++;
            if ({state, outs()} !== {seq[i].s, seq[i].o})
                $display("FAIL cond_exec step %0d: state=%0d outs=%b expected state=%0d outs=%b", i, state, outs(), seq[i].s, seq[i].o);
            else passed++;
            tick();
        end
    endtask

    task automatic test_add_imm();
        step_t seq [6];
        seq = '{
            '{32'hE2821005, 1'b0, 4'b0000, FETCH,  O_FETCH},
            '{32'hE2821005, 1'b1, 4'b0000, FETCH,  O_FETCH_RDY},
            '{32'hE2821005, 1'b0, 4'b0000, DECODE, O_NONE},
            '{32'hE2821005, 1'b0, 4'b0000, EXEC_I, O_IMM_ADD},
            '{32'hE2821005, 1'b0, 4'b0000, ALU_WB, O_ALU_WB},
            '{32'hE2821005, 1'b0, 4'b0000, FETCH,  O_FETCH}
        };
        for (int i = 0; i < $size(seq); i++) begin
            instr = seq[i].instr; mem_ready = seq[i].ready; alu_flags = seq[i].flags;
            #1;
            total++;
            if ({state, outs()} !== {seq[i].s, seq[i].o})
                $display("FAIL add_imm step %0d: state=%0d outs=%b expected state=%0d outs=%b", i, state, outs(), seq[i].s, seq[i].o);
            else passed++;
            tick();
        end
    endtask

    task automatic test_data_proc();
        step_t seq [16];
        seq = '{
            '{32'hE1811002, 1'b1, 4'b1011, FETCH,  O_FETCH_RDY},
            '{32'hE1811002, 1'b0, 4'b1011, DECODE, O_NONE},
            '{32'hE1811002, 1'b0, 4'b1011, EXEC_R, O_RM_ORR},
            '{32'hE1811002, 1'b0, 4'b1011, ALU_WB, O_ALU_WB},
            '{32'hE2511001, 1'b1, 4'b1011, FETCH,  O_FETCH_RDY},
            '{32'hE2511001, 1'b0, 4'b1011, DECODE, O_NONE},
            '{32'hE2511001, 1'b0, 4'b1011, EXEC_I, O_IMM_SUB_FLAGS},
            '{32'hE2511001, 1'b0, 4'b1011, ALU_WB, O_ALU_WB},
            '{32'hE0011002, 1'b1, 4'b1011, FETCH,  O_FETCH_RDY},
            '{32'hE0011002, 1'b0, 4'b1011, DECODE, O_NONE},
            '{32'hE0011002, 1'b0, 4'b1011, EXEC_R, O_RM_AND},
            '{32'hE0011002, 1'b0, 4'b1011, ALU_WB, O_ALU_WB},
            '{32'hE1A01002, 1'b1, 4'b1011, FETCH,  O_FETCH_RDY},
            '{32'hE1A01002, 1'b0, 4'b1011, DECODE, O_NONE},
            '{32'hE1A01002, 1'b0, 4'b1011, EXEC_R, O_NONE},
            '{32'hE1A01002, 1'b0, 4'b1011, FETCH,  O_FETCH}
        };
        for (int i = 0; i < $size(seq); i++) begin
            instr = seq[i].instr; mem_ready = seq[i].ready; alu_flags = seq[i].flags;
            #1;
            total++;
            if ({state, outs()} !== {seq[i].s, seq[i].o})
                $display("FAIL data_proc step %0d: state=%0d outs=%b expected state=%0d outs=%b", i, state, outs(), seq[i].s, seq[i].o);
            else passed++;
            tick();
        end
    endtask

    task automatic test_ldr();
        step_t seq [13];
        seq = '{
            '{32'hE5910008, 1'b1, 4'b0000, FETCH,   O_FETCH_RDY},
            '{32'hE5910008, 1'b0, 4'b0000, DECODE,  O_NONE},
            '{32'hE5910008, 1'b0, 4'b0000, MEM_ADR, O_IMM_ADD},
            '{32'hE5910008, 1'b0, 4'b0000, MEM_RD,  O_MEM_RD},
            '{32'hE5910008, 1'b0, 4'b0000, MEM_RD,  O_MEM_RD},
            '{32'hE5910008, 1'b1, 4'b0000, MEM_RD,  O_MEM_RD},
            '{32'hE5910008, 1'b0, 4'b0000, MEM_WB,  O_MEM_WB},
            '{32'hE5110008, 1'b1, 4'b0000, FETCH,   O_FETCH_RDY},
            '{32'hE5110008, 1'b0, 4'b0000, DECODE,  O_NONE},
            '{32'hE5110008, 1'b0, 4'b0000, MEM_ADR, O_IMM_SUB},
            '{32'hE5110008, 1'b1, 4'b0000, MEM_RD,  O_MEM_RD},
            '{32'hE5110008, 1'b0, 4'b0000, MEM_WB,  O_MEM_WB},
            '{32'hE5110008, 1'b0, 4'b0000, FETCH,   O_FETCH}
        };
        for (int i = 0; i < $size(seq); i++) begin
            instr = seq[i].instr; mem_ready = seq[i].ready; alu_flags = seq[i].flags;
            #1;
            total++;
            if ({state, outs()} !== {seq[i].s, seq[i].o})
                $display("FAIL ldr step %0d: state=%0d outs=%b expected state=%0d outs=%b", i, state, outs(), seq[i].s, seq[i].o);
            else passed++;
            tick();
        end
    endtask

    task automatic test_str();
        step_t seq [7];
        seq = '{
            '{32'hE5810008, 1'b1, 4'b0000, FETCH,   O_FETCH_RDY},
            '{32'hE5810008, 1'b0, 4'b0000, DECODE,  O_NONE},
            '{32'hE5810008, 1'b0, 4'b0000, MEM_ADR, O_IMM_ADD},
            '{32'hE5810008, 1'b0, 4'b0000, MEM_WR,  O_MEM_WR},
            '{32'hE5810008, 1'b0, 4'b0000, MEM_WR,  O_MEM_WR},
            '{32'hE5810008, 1'b1, 4'b0000, MEM_WR,  O_MEM_WR},
            '{32'hE5810008, 1'b0, 4'b0000, FETCH,   O_FETCH}
        };
        for (int i = 0; i < $size(seq); i++) begin
            instr = seq[i].instr; mem_ready = seq[i].ready; alu_flags = seq[i].flags;
            #1;
            total++;
            if ({state, outs()} !== {seq[i].s, seq[i].o})
                $display("FAIL str step %0d: state=%0d outs=%b expected state=%0d outs=%b", i, state, outs(), seq[i].s, seq[i].o);
            else passed++;
            tick();
        end
    endtask

    task automatic test_sys_op();
        step_t seq [4];
        seq = '{
            '{32'hEF000000, 1'b1, 4'b0000, FETCH,  O_FETCH_RDY},
            '{32'hEF000000, 1'b0, 4'b0000, DECODE, O_NONE},
            '{32'hEF000000, 1'b0, 4'b0000, FETCH,  O_FETCH},
            '{32'hEF000000, 1'b0, 4'b0000, FETCH,  O_FETCH}
        };
        for (int i = 0; i < $size(seq); i++) begin
            instr = seq[i].instr; mem_ready = seq[i].ready; alu_flags = seq[i].flags;
            #1;
            total++;
            if ({state, outs()} !== {seq[i].s, seq[i].o})
                $display("FAIL sys_op step %0d: state=%0d outs=%b expected state=%0d outs=%b", i, state, outs(), seq[i].s, seq[i].o);
            else passed++;
            tick();
        end
    endtask

    task automatic test_reset_mid_write();
        step_t seq [5];
        seq = '{
            '{32'hE5810008, 1'b1, 4'b0000, FETCH,   O_FETCH_RDY},
            '{32'hE5810008, 1'b0, 4'b0000, DECODE,  O_NONE},
            '{32'hE5810008, 1'b0, 4'b0000, MEM_ADR, O_IMM_ADD},
            '{32'hE5810008, 1'b0, 4'b0000, MEM_WR,  O_MEM_WR},
            '{32'hE5810008, 1'b0, 4'b0000, MEM_WR,  O_MEM_WR}
        };
        for (int i = 0; i < $size(seq); i++) begin
            instr = seq[i].instr; mem_ready = seq[i].ready; alu_flags = seq[i].flags;
            #1;
            total++;
            if ({state, outs()} !== {seq[i].s, seq[i].o})
                $display("FAIL rst_mid_wr step %0d: state=%0d outs=%b expected state=%0d outs=%b", i, state, outs(), seq[i].s, seq[i].o);
            else passed++;
            tick();
        end
        // Still waiting in MEM_WR; drop reset between clock edges.
        rst = 1'b0;
        #1;
        total++;
        if ({state, mem_req, mem_write} !== {FETCH, 1'b0, 1'b0})
            $display("FAIL rst_mid_wr_async: state=%0d mem_req=%b mem_write=%b expected state=%0d mem_req=0 mem_write=0", state, mem_req, mem_write, FETCH);
        else passed++;
        tick();
        total++;
        if ({state, outs()} !== {FETCH, O_NONE})
            $display("FAIL rst_mid_wr_held: state=%0d outs=%b expected state=%0d outs=%b", state, outs(), FETCH, O_NONE);
        else passed++;
        rst = 1'b1;
        #1;
        total++;
        if ({state, outs()} !== {FETCH, O_FETCH})
            $display("FAIL rst_mid_wr_release: state=%0d outs=%b expected state=%0d outs=%b", state, outs(), FETCH, O_FETCH);
        else passed++;
        tick();
        total++;
        if ({state, outs()} !== {FETCH, O_FETCH})
            $display("FAIL rst_mid_wr_abandon: state=%0d outs=%b expected state=%0d outs=%b", state, outs(), FETCH, O_FETCH);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_cond_exec();
        test_add_imm();
        test_data_proc();
        test_ldr();
        test_str();
        test_sys_op();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
